// File: rtl/vga_params.sv
// Shared VGA timing, framebuffer geometry and writer FSM encodings.
// Combinational constants only; no latency, no flow control.
package vga_params;
    localparam logic [9:0]  H_ACTIVE    = 10'd640;
    localparam logic [9:0]  H_TOTAL     = 10'd800;
    localparam logic [9:0]  V_ACTIVE    = 10'd480;
    localparam logic [9:0]  V_TOTAL     = 10'd525;
    localparam logic [7:0]  FB_W        = 8'd160;
    localparam logic [6:0]  FB_H        = 7'd120;
    localparam logic [14:0] FB_WORDS    = 15'd19200;
    localparam int          SCALE_SHIFT = 2;

    // Last in-line fetch slot (col 159) and the end-of-line slot that prefetches col 0.
    localparam logic [9:0]  H_LAST_SLOT = H_ACTIVE - 10'd6;
    localparam logic [9:0]  H_LINE_SLOT = H_TOTAL - 10'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wr_state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Row/col to framebuffer word address, plus writer address range check.
// Purely combinational; no flow control.
module fb_addr_gen
    import vga_params::*;
(
    input  logic [7:0]  i_row,
    input  logic [7:0]  i_col,
    input  logic [14:0] i_wr_addr,
    output logic [14:0] o_addr,
    output logic        o_wr_in_range
);
    logic [14:0] w_row_ext;

    assign w_row_ext     = {7'd0, i_row};
    // row*160 as row*128 + row*32 keeps it to shifts and adds.
    assign o_addr        = (w_row_ext << 7) + (w_row_ext << 5) + {7'd0, i_col};
    assign o_wr_in_range = (i_wr_addr < FB_WORDS);
endmodule

// File: rtl/vram_arbiter.sv
// Shares a single-port VRAM between the scan-out fetch and a pixel writer; display always wins.
// Memory outputs registered; pixel visible 2 cycles after its fetch slot; writer waits <=1 cycle, 1 write per 2 cycles.
module vram_arbiter
    import vga_params::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        bright,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  r,
    output logic [2:0]  g,
    output logic [1:0]  b
);
    logic [9:0]  w_nh;
    logic [9:0]  w_nl;
    logic [7:0]  w_row;
    logic [7:0]  w_col;
    logic        w_slot;
    logic [14:0] w_disp_addr;
    logic        w_wr_ok;
    logic        w_wr_go;
    wr_state_t   r_state;
    wr_state_t   w_state_nxt;

    logic [14:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_we;
    logic        r_wr_ack;
    logic        r_wr_err;
    logic        r_disp;
    logic        r_disp_d;
    logic [7:0]  r_pix;

    // Memory outputs are registered, so slot decisions look one pixel ahead.
    always_comb begin
        w_nh   = hcount + 10'd1;
        w_nl   = (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
        w_row  = vcount[9:2];
        w_col  = w_nh[9:2] + 8'd1;
        w_slot = 1'b0;
        if (w_nh[1:0] == 2'b10) begin
            if (w_nh <= H_LAST_SLOT) begin
                w_slot = (vcount < V_ACTIVE);
            end else if (w_nh == H_LINE_SLOT) begin
                w_row  = w_nl[9:2];
                w_col  = 8'd0;
                w_slot = (w_nl < V_ACTIVE);
            end
        end
    end

    fb_addr_gen u_addr_gen (
        .i_row         (w_row),
        .i_col         (w_col),
        .i_wr_addr     (wr_addr),
        .o_addr        (w_disp_addr),
        .o_wr_in_range (w_wr_ok)
    );

    assign w_wr_go = (r_state == ST_IDLE) && wr_req && !w_slot;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_wr_go) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_wr_err    <= 1'b0;
            r_disp      <= 1'b0;
            r_disp_d    <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_we <= 1'b0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_disp   <= w_slot;
            r_disp_d <= r_disp;
            if (w_slot) begin
                r_mem_addr <= w_disp_addr;
            end else if (w_wr_go && w_wr_ok) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
                r_mem_we    <= 1'b1;
            end
            // Out-of-range writes are acknowledged so the writer never stalls on them.
            if (w_wr_go) begin
                r_wr_ack <= 1'b1;
                r_wr_err <= !w_wr_ok;
            end
            if (r_disp_d) begin
                r_pix <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign wr_ack    = r_wr_ack;
    assign wr_err    = r_wr_err;
    assign r         = bright ? r_pix[7:5] : 3'd0;
    assign g         = bright ? r_pix[4:2] : 3'd0;
    assign b         = bright ? r_pix[1:0] : 2'd0;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and scripted-random bench for vram_arbiter with a 1-cycle-latency RAM model.
module tb_vram_arbiter;
    import vga_params::*;

    logic        clk;
    logic        rst;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        bright;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;

    logic        mem_clr;
    logic [7:0]  mem    [0:32767];
    logic [7:0]  shadow [0:19199];
    int          n_chk;
    int          n_fail;
    int          wait_cnt;
    int          n_wr;
    logic        mon_en;
    logic        prev_we;

    vram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .hcount    (h),
        .vcount    (v),
        .bright    (bright),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 8'h00;
            mem[323] <= 8'hE3;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic     slot;
        logic [9:0] l;
        int       row;
        int       col;
        slot = 1'b0;
        l    = (v == 10'd524) ? 10'd0 : v + 10'd1;
        row  = 0;
        col  = 0;
        if (h[1:0] == 2'b10) begin
            if (h <= 10'd634 && v < 10'd480) begin
                slot = 1'b1; row = int'(v >> 2); col = int'(h >> 2) + 1;
            end else if (h == 10'd798 && l < 10'd480) begin
                slot = 1'b1; row = int'(l >> 2); col = 0;
            end
        end
        if (slot) begin
            chk("disp_addr", 32'(mem_addr), 32'(row * 160 + col));
            chk("disp_we", 32'(mem_we), 32'd0);
        end
        if (mem_we) chk("we_b2b", 32'(prev_we), 32'd0);
        prev_we = mem_we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (h == 10'd799) begin
            h = 10'd0;
            v = (v == 10'd524) ? 10'd0 : v + 10'd1;
        end else begin
            h = h + 10'd1;
        end
        bright = (h < H_ACTIVE) && (v < V_ACTIVE);
        #1;
        if (mon_en) monitor();
    endtask

    task automatic set_pos(input logic [9:0] nh, input logic [9:0] nv);
        @(posedge clk);
        #1;
        h = nh;
        v = nv;
        bright = (nh < H_ACTIVE) && (nv < V_ACTIVE);
        #1;
    endtask

    task automatic writer(input logic allow);
        if (wr_req) begin
            if (wr_ack) begin
                chk("wr_lat", 32'(wait_cnt <= 1), 32'd1);
                chk("wr_err_rand", 32'(wr_err), 32'(wr_addr >= 15'd19200));
                if (wr_addr < 15'd19200) shadow[wr_addr] = wr_data;
                wr_req = 1'b0;
                n_wr++;
            end else begin
                wait_cnt++;
                if (wait_cnt >= 4) begin
                    chk("wr_ack_timeout", 32'(wr_ack), 32'd1);
                    wr_req = 1'b0;
                end
            end
        end else if (allow && $urandom_range(0, 2) == 0) begin
            wr_req   = 1'b1;
            wait_cnt = 0;
            if ($urandom_range(0, 7) == 0) wr_addr = 15'(19200 + $urandom_range(0, 500));
            else                           wr_addr = 15'(1600 + $urandom_range(0, 319));
            wr_data = 8'($urandom);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=%0d exp=%0d", n_chk, 0);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_fail = 0; wait_cnt = 0; n_wr = 0;
        mon_en = 1'b0; prev_we = 1'b0;
        rst = 1'b1; mem_clr = 1'b1;
        wr_req = 1'b1; wr_addr = 15'd5; wr_data = 8'hAA;
        h = 10'd0; v = 10'd0; bright = 1'b0;
        for (int i = 0; i < 19200; i++) shadow[i] = 8'h00;
        shadow[323] = 8'hE3;

        // Reset mid-line with a pending write request: nothing may leak out.
        set_pos(10'd2, 10'd8);
        mem_clr = 1'b0;
        step(); step(); step();
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_ack",   32'(wr_ack),    32'd0);
        chk("rst_err",   32'(wr_err),    32'd0);
        chk("rst_rgb",   32'({r, g, b}), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst = 1'b0; wr_req = 1'b0;

        step();
        chk("fetch_h6_addr", 32'(mem_addr), 32'd322);
        chk("fetch_h6_we",   32'(mem_we),   32'd0);
        chk("stale_pix",     32'({r, g, b}), 32'd0);
        step(); step(); step(); step();
        chk("fetch_h10_addr", 32'(mem_addr), 32'd323);
        chk("fetch_h10_we",   32'(mem_we),   32'd0);
        step();
        chk("pix_h11_old", 32'({r, g, b}), 32'd0);
        step();
        chk("pix_h12_r", 32'(r), 32'd7);
        chk("pix_h12_g", 32'(g), 32'd0);
        chk("pix_h12_b", 32'(b), 32'd3);

        // Line/frame wrap fetch and edge slots.
        set_pos(10'd797, 10'd524); step();
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        chk("wrap_we",   32'(mem_we),   32'd0);
        set_pos(10'd633, 10'd479); step();
        chk("lastcol_addr", 32'(mem_addr), 32'd19199);
        set_pos(10'd637, 10'd479); step();
        chk("free638_addr", 32'(mem_addr), 32'd19199);
        set_pos(10'd797, 10'd479); step();
        chk("nofetch480_addr", 32'(mem_addr), 32'd19199);
        chk("nofetch480_we",   32'(mem_we),   32'd0);

        // Writer collides with the slot at hcount=10.
        set_pos(10'd8, 10'd20); step();
        wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'h1C;
        step();
        chk("ww_we10",   32'(mem_we),   32'd0);
        chk("ww_ack10",  32'(wr_ack),   32'd0);
        chk("ww_addr10", 32'(mem_addr), 32'd803);
        step();
        chk("ww_we11",    32'(mem_we),    32'd1);
        chk("ww_ack11",   32'(wr_ack),    32'd1);
        chk("ww_err11",   32'(wr_err),    32'd0);
        chk("ww_addr11",  32'(mem_addr),  32'd100);
        chk("ww_wdata11", 32'(mem_wdata), 32'h1C);
        step();
        chk("ww_we12",  32'(mem_we), 32'd0);
        chk("ww_ack12", 32'(wr_ack), 32'd0);
        wr_req = 1'b0;
        shadow[100] = 8'h1C;

        // Out-of-range address, then the last valid word.
        set_pos(10'd700, 10'd20);
        wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 8'hFF;
        step();
        chk("oor_ack", 32'(wr_ack), 32'd1);
        chk("oor_err", 32'(wr_err), 32'd1);
        chk("oor_we",  32'(mem_we), 32'd0);
        wr_req = 1'b0;
        step();
        chk("oor_ack_clr", 32'(wr_ack), 32'd0);
        chk("oor_err_clr", 32'(wr_err), 32'd0);
        wr_req = 1'b1; wr_addr = 15'd19199; wr_data = 8'h5A;
        step();
        chk("max_we",    32'(mem_we),    32'd1);
        chk("max_ack",   32'(wr_ack),    32'd1);
        chk("max_err",   32'(wr_err),    32'd0);
        chk("max_addr",  32'(mem_addr),  32'd19199);
        chk("max_wdata", 32'(mem_wdata), 32'h5A);
        wr_req = 1'b0;
        shadow[19199] = 8'h5A;

        // Frame 1: random writes into rows 10..11 while scanning lines 36..47.
        set_pos(10'd799, 10'd35);
        prev_we = 1'b0;
        mon_en  = 1'b1;
        for (int c = 0; c < 12000; c++) begin
            step();
            writer(v < 10'd47);
            if (v >= 10'd47 && !wr_req) break;
        end
        chk("frame1_idle", 32'(wr_req), 32'd0);
        chk("frame1_writes", 32'(n_wr > 100), 32'd1);

        // Frame 2: read-only scan; every visible pixel of rows 10..11 must match.
        mon_en = 1'b0;
        set_pos(10'd799, 10'd38);
        prev_we = 1'b0;
        mon_en  = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            step();
            if (v >= 10'd40 && v <= 10'd47 && h < H_ACTIVE)
                chk("pix", 32'({r, g, b}), 32'(shadow[int'(v >> 2) * 160 + int'(h >> 2)]));
            if (v == 10'd47 && h == 10'd799) break;
        end
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
